// File: rtl/core_datapath.sv
// core_datapath: shared-bus register file, ALU and Z flag slaved to the control word.
// Define DATAPATH_MUL_EN to build the multiplier for aluOp 4 (otherwise aluOp 4 passes AC).
module core_datapath #(
   parameter int REG_WIDTH = 12,
   parameter int INS_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rstN,
   input  logic [2:0]           aluOp,
   input  logic [3:0]           incReg,
   input  logic [9:0]           wrEnReg,
   input  logic [3:0]           busSel,
   input  logic                 ZWrEn,
   input  logic [REG_WIDTH-1:0] dataMemOut,
   input  logic [INS_WIDTH-1:0] insMemOut,
   output logic [INS_WIDTH-1:0] ins,
   output logic                 Zout,
   output logic [REG_WIDTH-1:0] dataMemAddr,
   output logic [REG_WIDTH-1:0] dataMemIn,
   output logic [REG_WIDTH-1:0] insMemAddr,
   output logic [REG_WIDTH-1:0] busOut,
   output logic [REG_WIDTH-1:0] acOut
);
   logic [REG_WIDTH-1:0] ar, r, pc, rl, rc, rp, rq, r1, ac, bus, alu, mul;
   logic [INS_WIDTH-1:0] ir;
   logic                 z;
   always_comb begin
      bus = '0;
      case (busSel)
         4'd0:    bus = dataMemOut;
         4'd1:    bus = r;
         4'd2:    bus = REG_WIDTH'(ir);
         4'd3:    bus = rl;
         4'd4:    bus = rc;
         4'd5:    bus = rp;
         4'd6:    bus = rq;
         4'd7:    bus = r1;
         4'd8:    bus = ac;
         4'd9:    bus = REG_WIDTH'(insMemOut);
         4'd10:   bus = pc;
         default: bus = '0;
      endcase
   end
`ifdef DATAPATH_MUL_EN
   assign mul = ac * bus;
`else
   assign mul = ac;
`endif
   always_comb begin
      alu = ac;
      case (aluOp)
         3'd0:    alu = bus;
         3'd1:    alu = '0;
         3'd2:    alu = ac + bus;
         3'd3:    alu = ac - bus;
         3'd4:    alu = mul;
         3'd5:    alu = ac + 1'b1;
         default: alu = ac;
      endcase
   end
   // write enable takes priority over increment on the same register
   always_ff @(posedge clk) begin
      if (!rstN) begin
         ar <= '0;
         r  <= '0;
         pc <= '0;
         ir <= '0;
         rl <= '0;
         rc <= '0;
         rp <= '0;
         rq <= '0;
         r1 <= '0;
         ac <= '0;
         z  <= 1'b0;
      end else begin
         ar <= wrEnReg[9] ? bus : ar;
         r  <= wrEnReg[8] ? bus : r;
         pc <= wrEnReg[7] ? bus : incReg[3] ? pc + 1'b1 : pc;
         ir <= wrEnReg[6] ? bus[INS_WIDTH-1:0] : ir;
         rl <= wrEnReg[5] ? bus : rl;
         rc <= wrEnReg[4] ? bus : incReg[2] ? rc + 1'b1 : rc;
         rp <= wrEnReg[3] ? bus : incReg[1] ? rp + 1'b1 : rp;
         rq <= wrEnReg[2] ? bus : incReg[0] ? rq + 1'b1 : rq;
         r1 <= wrEnReg[1] ? bus : r1;
         ac <= wrEnReg[0] ? alu : ac;
         z  <= ZWrEn ? (alu == '0) : z;
      end
   end
   assign ins         = ir;
   assign Zout        = z;
   assign dataMemAddr = ar;
   assign dataMemIn   = r;
   assign insMemAddr  = pc;
   assign busOut      = bus;
   assign acOut       = ac;
endmodule

// File: tb/tb_core_datapath.sv
// tb_core_datapath: scoreboard bench for core_datapath; expectations queued at drive time.
module tb_core_datapath;
   localparam logic [9:0] W_AR = 10'h200, W_R = 10'h100, W_PC = 10'h080, W_IR = 10'h040,
                          W_RL = 10'h020, W_RP = 10'h008, W_AC = 10'h001;
   localparam logic [3:0] I_PC = 4'h8, I_RP = 4'h2;
   localparam int O_AC = 0, O_PC = 1, O_INS = 2, O_Z = 3, O_AR = 4, O_R = 5, O_BUS = 6;
   typedef struct {
      string       tag;
      int          what;
      logic [11:0] exp;
   } exp_t;
   logic        clk = 1'b0, rstN = 1'b1, ZWrEn = 1'b0;
   logic [2:0]  aluOp = '0;
   logic [3:0]  incReg = '0, busSel = '0;
   logic [9:0]  wrEnReg = '0;
   logic [11:0] dataMemOut = '0, dataMemAddr, dataMemIn, insMemAddr, busOut, acOut;
   logic [7:0]  insMemOut = '0, ins;
   logic        Zout;
   int          checks = 0, failures = 0;
   exp_t        sb[$];
   core_datapath dut (
      .clk(clk), .rstN(rstN), .aluOp(aluOp), .incReg(incReg), .wrEnReg(wrEnReg),
      .busSel(busSel), .ZWrEn(ZWrEn), .dataMemOut(dataMemOut), .insMemOut(insMemOut),
      .ins(ins), .Zout(Zout), .dataMemAddr(dataMemAddr), .dataMemIn(dataMemIn),
      .insMemAddr(insMemAddr), .busOut(busOut), .acOut(acOut)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
      end
   endtask
   function automatic logic [11:0] obs(input int what);
      case (what)
         O_AC:    return acOut;
         O_PC:    return insMemAddr;
         O_INS:   return 12'(ins);
         O_Z:     return 12'(Zout);
         O_AR:    return dataMemAddr;
         O_R:     return dataMemIn;
         default: return busOut;
      endcase
   endfunction
   task automatic expect_out(input string tag, input int what, input logic [11:0] exp);
      sb.push_back('{tag, what, exp});
   endtask
   task automatic drive(input logic [2:0] op, input logic [3:0] inc, input logic [9:0] wr,
                        input logic [3:0] sel, input logic zw, input logic [11:0] dm,
                        input logic [7:0] im);
      aluOp = op; incReg = inc; wrEnReg = wr; busSel = sel; ZWrEn = zw;
      dataMemOut = dm; insMemOut = im;
   endtask
   task automatic cycle();
      exp_t e;
      @(posedge clk);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         check(e.tag, obs(e.what), e.exp);
      end
   endtask
   initial begin
      rstN = 1'b0;
      cycle();
      rstN = 1'b1;
      // reset test setup: AC=5, PC=7, Z=1
      drive(0, 0, W_AC, 9, 0, 0, 8'h05); expect_out("ld_ac5", O_AC, 12'h005); cycle();
      drive(0, 0, W_PC, 9, 0, 0, 8'h07); expect_out("ld_pc7", O_PC, 12'h007); cycle();
      drive(1, 0, 0, 9, 1, 0, 8'h07);
      expect_out("set_z", O_Z, 12'h1); expect_out("ac_hold", O_AC, 12'h005); cycle();
      rstN = 1'b0;
      drive(2, 4'hF, 10'h3FF, 1, 1, 12'hABC, 8'h33);
      expect_out("rst_ac", O_AC, 0); expect_out("rst_pc", O_PC, 0);
      expect_out("rst_ins", O_INS, 0); expect_out("rst_z", O_Z, 0);
      expect_out("rst_ar", O_AR, 0); expect_out("rst_r", O_R, 0);
      expect_out("rst_bus", O_BUS, 0); cycle();
      rstN = 1'b1;
      // immediate load and add
      drive(0, 0, W_AC, 9, 0, 0, 8'h2A); expect_out("imm_ac", O_AC, 12'h02A); cycle();
      drive(0, 0, W_RL, 8, 0, 0, 0); expect_out("bus_ac", O_BUS, 12'h02A); cycle();
      drive(2, 0, W_AC, 3, 1, 0, 0);
      expect_out("add_ac", O_AC, 12'h054); expect_out("add_z", O_Z, 0);
      expect_out("bus_rl", O_BUS, 12'h02A); cycle();
      // wrap and Z
      drive(0, 0, W_AC, 0, 0, 12'hFFF, 0); expect_out("ld_fff", O_AC, 12'hFFF); cycle();
      drive(5, 0, W_AC, 0, 1, 0, 0);
      expect_out("inc_wrap", O_AC, 12'h000); expect_out("inc_z", O_Z, 1); cycle();
      drive(3, 0, W_AC, 0, 1, 12'h001, 0);
      expect_out("sub_wrap", O_AC, 12'hFFF); expect_out("sub_z", O_Z, 0); cycle();
      drive(1, 0, 0, 0, 0, 0, 0); expect_out("z_hold", O_Z, 0); expect_out("ac_hold2", O_AC, 12'hFFF); cycle();
      // increment/write conflict and PC wrap
      drive(0, 0, W_PC, 9, 0, 0, 8'h03); expect_out("pc3", O_PC, 12'h003); cycle();
      drive(0, I_PC, W_PC, 0, 0, 12'h100, 0); expect_out("wr_wins", O_PC, 12'h100); cycle();
      drive(0, 0, W_PC, 0, 0, 12'hFFF, 0); expect_out("pc_fff", O_PC, 12'hFFF); cycle();
      drive(0, I_PC, 0, 0, 0, 0, 0); expect_out("pc_wrap", O_PC, 12'h000); cycle();
      // multiply
      drive(0, 0, W_AC, 0, 0, 12'h040, 0); expect_out("ld_40", O_AC, 12'h040); cycle();
      drive(0, 0, W_RP, 0, 0, 12'h041, 0); cycle();
      drive(4, 0, W_AC, 5, 1, 0, 0);
      expect_out("mul_trunc", O_AC, 12'h040); expect_out("mul_z", O_Z, 0); cycle();
      drive(4, 0, W_AC, 0, 0, 12'h003, 0);
`ifdef DATAPATH_MUL_EN
      expect_out("mul_3", O_AC, 12'h0C0);
`else
      expect_out("mul_3", O_AC, 12'h040);
`endif
      cycle();
      drive(0, I_RP, 0, 5, 0, 0, 0); expect_out("rp_inc", O_BUS, 12'h042); cycle();
      // fetch path and same-cycle old-value reads
      drive(0, I_PC, W_IR, 9, 0, 0, 8'h1F);
      expect_out("fetch_ins", O_INS, 12'h01F); expect_out("fetch_pc", O_PC, 12'h001); cycle();
      drive(0, I_PC, W_AR, 10, 0, 0, 0);
      expect_out("ar_oldpc", O_AR, 12'h001); expect_out("pc2", O_PC, 12'h002); cycle();
      drive(0, 0, W_IR, 2, 0, 0, 0); expect_out("ir_self", O_INS, 12'h01F); cycle();
      drive(0, 0, W_AR | W_R, 0, 0, 12'h5A5, 0);
      expect_out("multi_ar", O_AR, 12'h5A5); expect_out("multi_r", O_R, 12'h5A5); cycle();
      drive(0, 0, 0, 13, 0, 12'h777, 8'hFF); expect_out("sel13", O_BUS, 12'h000); cycle();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/core_datapath.md
# core_datapath

Register-and-bus datapath of one processor core, directly downstream of `controlUnit`. It consumes the control word each cycle and drives the core's registers, single shared bus, ALU and Z flag:

- Control word: `aluOp`, `incReg`, `wrEnReg`, `busSel`, `ZWrEn`.
- Registers: AR, R, PC, IR, RL, RC, RP, RQ, R1, AC.

It returns the instruction register (`ins`) and `Zout` to the control unit, and drives the instruction- and data-memory address/data ports.

## Interface
- `REG_WIDTH`, 12: width of every data register, the bus and the ALU.
- `INS_WIDTH`, 8: width of IR, of `ins` and of `insMemOut`.

Ports:
- `clk`  in  1  core clock; all state updates on rising edge.
- `rstN`  in  1  synchronous active-low reset.
- `aluOp`  in  3  ALU operation select.
- `incReg`  in  4  increment enables {PC, RC, RP, RQ}.
- `wrEnReg`  in  10  write enables {AR, R, PC, IR, RL, RC, RP, RQ, R1, AC}.
- `busSel`  in  4  bus source select.
- `ZWrEn`  in  1  Z flag write enable.
- `dataMemOut`  in  REG_WIDTH  read data from data memory.
- `insMemOut`  in  INS_WIDTH  read data from instruction memory.
- `ins`  out  INS_WIDTH  IR contents, to control unit.
- `Zout`  out  1  Z flag.
- `dataMemAddr`  out  REG_WIDTH  AR contents.
- `dataMemIn`  out  REG_WIDTH  R contents (store data).
- `insMemAddr`  out  REG_WIDTH  PC contents.
- `busOut`  out  REG_WIDTH  current bus value, for debug/observation.
- `acOut`  out  REG_WIDTH  AC contents.

## Operation
- **Bus** is combinational from current register values. `busSel` sources:
  - 0 `dataMemOut`; 1 R; 2 IR (zero-extended); 3 RL; 4 RC; 5 RP; 6 RQ; 7 R1; 8 AC; 9 `insMemOut` (zero-extended); 10 PC.
  - Values 11–15 drive 0.
- **Register writes:** AR, R, PC, RL, RC, RP, RQ and R1 load the bus when their `wrEnReg` bit is set. IR loads `bus[INS_WIDTH-1:0]`.
- **AC** loads the ALU result when `wrEnReg[0]`. The ALU computes A = AC, B = bus:
  - 0 pass B; 1 clear (0); 2 A+B; 3 A−B; 4 A×B (low REG_WIDTH bits); 5 A+1.
  - Values 6–7 pass A.
- **Arithmetic** is unsigned and modulo 2^REG_WIDTH. Carry, borrow and the high product bits are discarded: 0xFFF+1 = 0; 0−1 = 0xFFF.
- **Z flag:** when `ZWrEn`, Z ← (ALU result == 0). It is computed from the same-cycle ALU result, independent of `wrEnReg[0]`.
- **Increment:** when a bit of `incReg` is set, the corresponding register ← register+1, wrapping at all-ones to 0.
- **Write vs increment:** if write enable and increment are both set for the same register in the same cycle, the write wins.
- **Multiple writes:** several registers may be written in one cycle from the same bus value, in any combination.
- Any register, including IR and PC, may be read onto the bus in the same cycle it is written. The bus carries the old value.

## Timing
- **Reset:** when `rstN` is low at a rising edge, all ten registers and Z clear to 0. As a result, `ins`, `Zout`, `dataMemAddr`, `dataMemIn`, `insMemAddr` and `acOut` are 0 from the next cycle.
  - `busOut` follows the selected source (0 after reset for register sources).
  - Reset overrides all enables, including reset mid-instruction.
- **Write latency:** one cycle. A value written at edge N is visible on outputs and bus after edge N.
- **Combinational paths:** `busSel` → `busOut` → ALU → AC/Z inputs is one combinational cycle. There are no internal pipeline stages.
- **Memory reads:** `dataMemOut` and `insMemOut` are sampled via the bus in the cycle they are selected. Memory read latency is handled by the control unit's state sequencing, not here.
- No handshake; the datapath is fully slaved to the control word.

## Configuration
- `DATAPATH_MUL_EN`:
  - Defined: `aluOp` 4 produces A×B (low REG_WIDTH bits), built from a REG_WIDTH×REG_WIDTH multiplier.
  - Undefined: no multiplier is instantiated and `aluOp` 4 passes A unchanged. Z still updates from that result when `ZWrEn`.

## Test plan
- **Reset:** load AC=5, PC=7, Z=1; assert `rstN`=0 for one edge → all outputs 0 next cycle, despite `wrEnReg`=all-ones being held during reset.
- **Immediate load and add:** `insMemOut`=0x2A, busSel=9, aluOp=0, wrEnReg[AC] → AC=0x2A. Then busSel=8, wrEnReg[RL] → RL=0x2A. Then busSel=3, aluOp=2, wrEnReg[AC], ZWrEn → AC=0x54, Z=0.
- **Wrap and Z:** AC=0xFFF, aluOp=5, wrEnReg[AC], ZWrEn → AC=0x000, Z=1. Also AC=0, SUB with bus=1 → AC=0xFFF, Z=0.
- **Increment/write conflict:** PC=3, incReg[PC]=1 with wrEnReg[PC]=1 and bus=0x100 → PC=0x100. PC=0xFFF with incReg only → PC=0.
- **Multiply:** with the macro defined, AC=0x040, RP=0x041, aluOp=4, busSel=5 → AC=0x040 (0x1040 truncated). Without the macro → AC unchanged (0x040).
- **Fetch path:** `insMemOut`=0x1F, busSel=9, wrEnReg[IR] and incReg[PC] → `ins`=0x1F and `insMemAddr`=old+1 in the same next cycle. Unused busSel=13 → `busOut`=0.
